// File: rtl/mixed_capture_fifo.sv
// Capture FIFO behind a no-backpressure register stage: absorbs every valid word,
// re-presents words over valid/ready and counts overflow drops. MIXED_CAPTURE_DEDUP_EN adds repeat-word suppression.
module mixed_capture_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      in_data,
  input  logic [7:0]       in_addr,
  input  logic             in_valid,
  output logic [15:0]      out_data,
  output logic [7:0]       out_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic             full,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam int unsigned ENTRY_W = 24;
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [ENTRY_W-1:0] in_word;
  logic               pop;
  logic               dup;
  logic               cand;
  logic               push;
  logic               drop;
  logic [AW:0]        level_nxt;

  assign in_word = {in_addr, in_data};

`ifdef MIXED_CAPTURE_DEDUP_EN
  // Last word actually written; overflow drops never update it.
  logic               has_last;
  logic [ENTRY_W-1:0] last_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      has_last  <= 1'b0;
      last_word <= '0;
    end else if (push) begin
      has_last  <= 1'b1;
      last_word <= in_word;
    end
  end

  assign dup = has_last && (last_word == in_word);
`else
  assign dup = 1'b0;
`endif

  // Handshake qualification; a suppressed duplicate is neither a push nor a drop.
  always_comb begin
    pop  = out_valid && out_ready;
    cand = in_valid && !dup;
    push = cand && (!full || pop);
    drop = cand && full && !pop;
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + (AW+1)'(1);
      2'b01:   level_nxt = level - (AW+1)'(1);
      default: level_nxt = level;
    endcase
  end

  assign overflow = drop;

  // Show-ahead head word; forced to zero while empty.
  assign {out_addr, out_data} = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_valid  <= 1'b0;
      full       <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      full      <= (level_nxt == LEVEL_FULL);
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule
